// File: rtl/case_1_sdiv_9s_5s_seq.sv
// Sequential signed divider with ap_ctrl_hs handshake: radix-2 restoring divide on
// magnitudes, then sign fix-up; quotient truncates toward zero.
module case_1_sdiv_9s_5s_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 9
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         ap_start,
  output logic                         ap_done,
  output logic                         ap_ready,
  output logic                         ap_idle,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic signed [dout_WIDTH-1:0] quot,
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         div_by_zero,
  output logic                         ovf
);

  localparam int N  = din0_WIDTH;
  localparam int M  = din1_WIDTH;
  localparam int CW = $clog2(N);
  localparam logic signed [N-1:0] MIN_N = {1'b1, {(N-1){1'b0}}};

  if (ID < 0 || M < 2 || M > N || dout_WIDTH != N) begin : g_bad_params
    $error("case_1_sdiv_9s_5s_seq: invalid width parameters");
  end

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;

  // dvd: dividend bits leave at the top while quotient bits enter at the bottom
  logic [N-1:0]    dvd;
  logic [M-1:0]    dvs;
  logic [M-1:0]    prem;
  logic            sign_q;
  logic            sign_r;
  logic            dbz_c;
  logic            ovf_c;
  logic [M-1:0]    din0_lo;

  logic [N-1:0]    din0_mag;
  logic [M-1:0]    din1_mag;
  logic [M-1:0]    prem_sh;
  logic            fits;

  // Two's-complement negation of the most negative value yields 2^(W-1),
  // which is exactly the magnitude when read back as unsigned.
  function automatic logic [N-1:0] mag_n(input logic signed [N-1:0] v);
    return v[N-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [M-1:0] mag_m(input logic signed [M-1:0] v);
    return v[M-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [N-1:0] apply_sign_n(input logic [N-1:0] v,
                                                       input logic       neg);
    return neg ? -$signed(v) : $signed(v);
  endfunction

  function automatic logic signed [M-1:0] apply_sign_m(input logic [M-1:0] v,
                                                       input logic       neg);
    return neg ? -$signed(v) : $signed(v);
  endfunction

  // The partial remainder stays below |divisor| <= 2^(M-1), so its top bit is
  // always clear and the shifted value still fits in M bits.
  always_comb begin
    din0_mag = mag_n(din0);
    din1_mag = mag_m(din1);
    prem_sh  = {prem[M-2:0], dvd[N-1]};
    fits     = (prem_sh >= dvs);
  end

  always_ff @(posedge ap_clk) begin
    if (state == IDLE && ap_start) begin
      dvd     <= din0_mag;
      dvs     <= din1_mag;
      prem    <= '0;
      sign_q  <= din0[N-1] ^ din1[M-1];
      sign_r  <= din0[N-1];
      dbz_c   <= (din1 == '0);
      ovf_c   <= (din0 == MIN_N) && (din1 == '1);
      din0_lo <= din0[M-1:0];
    end else if (state == CALC) begin
      prem <= fits ? (prem_sh - dvs) : prem_sh;
      dvd  <= {dvd[N-2:0], fits};
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      ap_done     <= 1'b0;
      ap_ready    <= 1'b0;
      ap_idle     <= 1'b1;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      ovf         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ap_start) begin
            state   <= CALC;
            cnt     <= CW'(N - 1);
            ap_idle <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt - CW'(1);
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          state    <= DONE;
          ap_done  <= 1'b1;
          ap_ready <= 1'b1;
          if (dbz_c) begin
            quot        <= '1;
            rem         <= din0_lo;
            div_by_zero <= 1'b1;
            ovf         <= 1'b0;
          end else if (ovf_c) begin
            quot        <= MIN_N;
            rem         <= '0;
            div_by_zero <= 1'b0;
            ovf         <= 1'b1;
          end else begin
            quot        <= apply_sign_n(dvd, sign_q);
            rem         <= apply_sign_m(prem, sign_r);
            div_by_zero <= 1'b0;
            ovf         <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          ap_done  <= 1'b0;
          ap_ready <= 1'b0;
          ap_idle  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_1_sdiv_9s_5s_seq.sv
// Directed bench for the 9s/5s sequential signed divider: arithmetic, corner cases,
// handshake timing, back-to-back throughput and asynchronous reset mid-operation.
module tb_case_1_sdiv_9s_5s_seq;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic              ap_start;
  logic              ap_done, ap_ready, ap_idle;
  logic signed [8:0] din0, quot;
  logic signed [4:0] din1, rem;
  logic              div_by_zero, ovf;

  int checks = 0;
  int errors = 0;

  int ta[9]  = '{100, -100, 100, -100, 255, -256, -256, 0, -1};
  int tb_[9] = '{7,   7,    -7,  -7,   -16, -16,  15,   5, 2};
  int tq[9]  = '{14,  -14,  -14, 14,   -15, 16,   -17,  0, 0};
  int tr[9]  = '{2,   -2,   2,   -2,   15,  0,    -1,   0, -1};

  always #5 ap_clk = ~ap_clk;

  case_1_sdiv_9s_5s_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_done     (ap_done),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .din0        (din0),
    .din1        (din1),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  // Launches one operation and returns the number of edges from accept to ap_done
  // (-1 if ap_done never arrives). Inputs are scrambled after the accept edge.
  task automatic run_op(input logic signed [8:0] a, input logic signed [4:0] b,
                        input bit poke, output int lat);
    @(posedge ap_clk); #1;
    ap_start = 1'b1; din0 = a; din1 = b;
    @(posedge ap_clk); #1;
    ap_start = 1'b0; din0 = 9'sh0AA; din1 = 5'sh0B;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 4) ap_start = 1'b1;
      if (poke && k == 6) ap_start = 1'b0;
      @(posedge ap_clk); #1;
      if (ap_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    ap_rst_n = 1'b0; ap_start = 1'b0; din0 = '0; din1 = '0;
    #12;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || ap_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: idle=%b done=%b ready=%b, expected 1 0 0", ap_idle, ap_done, ap_ready);
    end
    checks++;
    if (quot !== 9'sd0 || rem !== 5'sd0 || div_by_zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: quot=%0d rem=%0d dbz=%b ovf=%b, expected all 0", quot, rem, div_by_zero, ovf);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
  endtask

  task automatic test_arith;
    int lat;
    for (int i = 0; i < 9; i++) begin
      run_op(9'(ta[i]), 5'(tb_[i]), 1'b0, lat);
      checks++;
      if (lat !== 10 || ap_ready !== 1'b1 || ap_idle !== 1'b0) begin
        errors++;
        $display("FAIL arith_timing[%0d]: latency=%0d ready=%b idle=%b, expected 10 1 0", i, lat, ap_ready, ap_idle);
      end
      checks++;
      if (quot !== 9'(tq[i]) || rem !== 5'(tr[i])) begin
        errors++;
        $display("FAIL arith_value[%0d] %0d/%0d: quot=%0d rem=%0d, expected %0d %0d", i, ta[i], tb_[i], quot, rem, tq[i], tr[i]);
      end
      checks++;
      if (div_by_zero !== 1'b0 || ovf !== 1'b0) begin
        errors++;
        $display("FAIL arith_flags[%0d]: dbz=%b ovf=%b, expected 0 0", i, div_by_zero, ovf);
      end
    end
  endtask

  task automatic test_div_by_zero;
    int lat;
    run_op(9'sd5, 5'sd0, 1'b0, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL dbz_latency: got %0d, expected 10", lat);
    end
    checks++;
    if (quot !== 9'h1FF || rem !== 5'sd5 || div_by_zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL dbz_pos: quot=%h rem=%0d dbz=%b ovf=%b, expected 1ff 5 1 0", quot, rem, div_by_zero, ovf);
    end
    run_op(-9'sd7, 5'sd0, 1'b0, lat);
    checks++;
    if (quot !== 9'h1FF || rem !== -5'sd7 || div_by_zero !== 1'b1 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL dbz_neg: quot=%h rem=%0d dbz=%b ovf=%b, expected 1ff -7 1 0", quot, rem, div_by_zero, ovf);
    end
  endtask

  task automatic test_overflow;
    int lat;
    run_op(-9'sd256, -5'sd1, 1'b0, lat);
    checks++;
    if (lat !== 10 || quot !== 9'h100 || rem !== 5'sd0 || ovf !== 1'b1 || div_by_zero !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set: lat=%0d quot=%h rem=%0d ovf=%b dbz=%b, expected 10 100 0 1 0", lat, quot, rem, ovf, div_by_zero);
    end
    run_op(9'sd255, -5'sd16, 1'b0, lat);
    checks++;
    if (quot !== -9'sd15 || rem !== 5'sd15 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear: quot=%0d rem=%0d ovf=%b, expected -15 15 0", quot, rem, ovf);
    end
  endtask

  task automatic test_start_ignored;
    int lat;
    int bad;
    run_op(9'sd20, 5'sd3, 1'b1, lat);
    checks++;
    if (lat !== 10 || quot !== 9'sd6 || rem !== 5'sd2) begin
      errors++;
      $display("FAIL busy_start: lat=%0d quot=%0d rem=%0d, expected 10 6 2", lat, quot, rem);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge ap_clk); #1;
      if (ap_idle !== 1'b1 || ap_done !== 1'b0 || quot !== 9'sd6) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL no_queue: %0d cycles not idle/holding, expected 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    int done_at[3];
    int nd;
    int unstable;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; din0 = 9'sd50; din1 = 5'sd3;
    @(posedge ap_clk); #1;
    nd = 0; unstable = 0;
    for (int c = 1; c <= 45 && nd < 3; c++) begin
      @(posedge ap_clk); #1;
      if (nd > 0 && (quot !== 9'sd16 || rem !== 5'sd2)) unstable++;
      if (ap_done) begin
        done_at[nd] = c;
        nd++;
      end
    end
    ap_start = 1'b0;
    checks++;
    if (nd != 3) begin
      errors++;
      $display("FAIL b2b_count: saw %0d results, expected 3", nd);
    end else begin
      checks++;
      if (done_at[0] != 10 || done_at[1] - done_at[0] != 12 || done_at[2] - done_at[1] != 12) begin
        errors++;
        $display("FAIL b2b_spacing: done at %0d %0d %0d, expected 10 22 34", done_at[0], done_at[1], done_at[2]);
      end
    end
    checks++;
    if (unstable != 0 || quot !== 9'sd16 || rem !== 5'sd2) begin
      errors++;
      $display("FAIL b2b_hold: %0d unstable cycles, quot=%0d rem=%0d, expected 0 16 2", unstable, quot, rem);
    end
    repeat (2) @(posedge ap_clk);
    #1;
    checks++;
    if (ap_idle !== 1'b1) begin
      errors++;
      $display("FAIL b2b_stop: idle=%b, expected 1", ap_idle);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int spurious;
    @(posedge ap_clk); #1;
    ap_start = 1'b1; din0 = 9'sd100; din1 = 5'sd7;
    @(posedge ap_clk); #1;
    ap_start = 1'b0;
    repeat (3) @(posedge ap_clk);
    #1;
    ap_rst_n = 1'b0;
    #1;
    checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0 || quot !== 9'sd0 || rem !== 5'sd0) begin
      errors++;
      $display("FAIL rst_mid: idle=%b done=%b quot=%0d rem=%0d, expected 1 0 0 0", ap_idle, ap_done, quot, rem);
    end
    @(posedge ap_clk); #1;
    ap_rst_n = 1'b1;
    spurious = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge ap_clk); #1;
      if (ap_done !== 1'b0 || ap_idle !== 1'b1) spurious++;
    end
    checks++;
    if (spurious != 0) begin
      errors++;
      $display("FAIL rst_discard: %0d cycles busy/done after reset, expected 0", spurious);
    end
    run_op(9'sd7, 5'sd2, 1'b0, lat);
    checks++;
    if (lat !== 10 || quot !== 9'sd3 || rem !== 5'sd1 || div_by_zero !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL rst_recover: lat=%0d quot=%0d rem=%0d, expected 10 3 1", lat, quot, rem);
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_div_by_zero();
    test_overflow();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
